// File: rtl/fop_seq_detector.sv
// Sequential Fibonacci-or-prime classifier: Fibonacci walk, then trial division.
// Optional FOP_CNT_EN adds a saturating 16-bit count of handshakes with out_fop=1.
module fop_seq_detector #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_fib,
  output logic             out_prime,
  output logic             out_fop
`ifdef FOP_CNT_EN
  ,output logic [15:0]     hit_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FIB, PRIME, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   x_q, x_d, d_q, d_d, r_q, r_d;
  logic [WIDTH+1:0]   a_q, a_d, b_q, b_d;
  logic               fib_q, fib_d, prime_q, prime_d;
  logic               pent_q, pent_d, vld_q, vld_d;
  logic [WIDTH+1:0]   xw;
  logic [2*WIDTH-1:0] dp1, sq;

  assign xw  = {2'b00, x_q};
  assign dp1 = (2*WIDTH)'(d_q) + (2*WIDTH)'(1);
  assign sq  = dp1 * dp1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fib_q   <= 1'b0;
      prime_q <= 1'b0;
      pent_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      d_q     <= d_d;
      r_q     <= r_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fib_q   <= fib_d;
      prime_q <= prime_d;
      pent_q  <= pent_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    d_d     = d_q;
    r_d     = r_q;
    a_d     = a_q;
    b_d     = b_q;
    fib_d   = fib_q;
    prime_d = prime_q;
    pent_d  = pent_q;
    vld_d   = vld_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        x_d     = in_data;
        a_d     = '0;
        b_d     = (WIDTH+2)'(1);
        state_d = FIB;
      end
      FIB: begin
        if (a_q == xw) begin
          fib_d   = 1'b1;
          pent_d  = 1'b1;
          state_d = PRIME;
        end else if (a_q > xw) begin
          fib_d   = 1'b0;
          pent_d  = 1'b1;
          state_d = PRIME;
        end else begin
          a_d = b_q;
          b_d = a_q + b_q;
        end
      end
      PRIME: begin
        if (pent_q) begin
          pent_d = 1'b0;
          if (x_q < WIDTH'(2)) begin
            prime_d = 1'b0;
            state_d = DONE;
          end else if (x_q < WIDTH'(4)) begin
            prime_d = 1'b1;
            state_d = DONE;
          end else begin
            d_d = WIDTH'(2);
            r_d = x_q;
          end
        end else if (r_q >= d_q) begin
          r_d = r_q - d_q;
        end else if (r_q == '0) begin
          prime_d = 1'b0;
          state_d = DONE;
        end else if (sq > (2*WIDTH)'(x_q)) begin
          prime_d = 1'b1;
          state_d = DONE;
        end else begin
          d_d = d_q + WIDTH'(1);
          r_d = x_q;
        end
      end
      DONE: begin
        // out_valid comes up one cycle after entering DONE; the handshake only counts once it is up
        if (!vld_q) begin
          vld_d = 1'b1;
        end else if (out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = vld_q;
  assign out_fib   = vld_q & fib_q;
  assign out_prime = vld_q & prime_q;
  assign out_fop   = vld_q & (fib_q | prime_q);

`ifdef FOP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hit_cnt <= '0;
    else if (vld_q && out_ready && (fib_q || prime_q) && hit_cnt != 16'hFFFF)
      hit_cnt <= hit_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fop_seq_detector.sv
// Randomized self-checking bench for fop_seq_detector against a plain arithmetic model.
module tb_fop_seq_detector;
  localparam int WIDTH = 8;
  localparam int TMO   = 4 * (1 << WIDTH);

  logic             clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic             out_fib, out_prime, out_fop;
  logic [WIDTH-1:0] in_data;
`ifdef FOP_CNT_EN
  logic [15:0]      hit_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_hits = 0;

  fop_seq_detector #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_fib(out_fib), .out_prime(out_prime), .out_fop(out_fop)
`ifdef FOP_CNT_EN
    ,.hit_cnt(hit_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit m_fib(input int x);
    int p = 0, q = 1, t;
    while (p < x) begin
      t = p + q;
      p = q;
      q = t;
    end
    return p == x;
  endfunction

  function automatic bit m_prime(input int x);
    if (x < 2) return 1'b0;
    for (int k = 2; k * k <= x; k++)
      if (x % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Called #1 after a rising edge; the next rising edge is the accept edge.
  task automatic accept(input int x);
    int n = 0;
    in_data  = WIDTH'(x);
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run(input int x, input int hold, output int lat);
    bit ef, ep;
    ef = m_fib(x);
    ep = m_prime(x);
    out_ready = (hold == 0);
    accept(x);
    lat = 0;
    while (!out_valid && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("valid x=%0d", x), out_valid, 1);
    chk($sformatf("fib x=%0d", x), out_fib, ef);
    chk($sformatf("prime x=%0d", x), out_prime, ep);
    chk($sformatf("fop x=%0d", x), out_fop, ef | ep);
    for (int k = 0; k < hold; k++) begin
      if (hold >= 6 && k == 2) begin
        in_data  = WIDTH'(3);
        in_valid = 1'b1;
      end
      if (hold >= 6 && k == 4) in_valid = 1'b0;
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_prime", out_prime, ep);
      chk("hold_fop", out_fop, ef | ep);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    if (ef | ep) exp_hits++;
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_fop", {out_fib, out_prime, out_fop}, 0);
    chk("rst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("idle_in_ready", in_ready, 1);
    @(posedge clk); #1;

    for (int x = 0; x < 16; x++) begin
      run(x, 0, lat);
      if (x == 0) chk("lat_x0", lat, 3);
      if (x == 2) chk("lat_x2", lat, 6);
    end
`ifdef FOP_CNT_EN
    chk("hit_cnt_sweep", hit_cnt, 9);
`endif

    run(144, 0, lat);
    run(251, 0, lat);
    run(255, 0, lat);
    run(233, 0, lat);

    // Backpressure with an ignored in_valid pulse while in DONE.
    run(7, 10, lat);

    for (int i = 0; i < 30; i++)
      run($urandom_range(0, (1 << WIDTH) - 1), $urandom_range(0, 3), lat);
`ifdef FOP_CNT_EN
    chk("hit_cnt_rand", hit_cnt, exp_hits);
`endif

    // Reset asserted mid-PRIME on 251: no result may follow.
    out_ready = 1'b1;
    accept(251);
    repeat (25) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_res", {out_fib, out_prime, out_fop}, 0);
    chk("midrst_in_ready", in_ready, 0);
`ifdef FOP_CNT_EN
    chk("midrst_hit_cnt", hit_cnt, 0);
`endif
    exp_hits = 0;
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("after_rst_in_ready", in_ready, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("after_rst_no_valid", out_valid, 0);
    end
    run(5, 0, lat);
`ifdef FOP_CNT_EN
    chk("hit_cnt_final", hit_cnt, exp_hits);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
